// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_pkg: funct3 store encodings and the buffered store entry type.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mem_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    // Entry address width; the top level zero-extends or truncates into it.
    localparam int ST_ADDR_W = 32;

    typedef struct packed {
        logic [ST_ADDR_W-1:0] addr;
        logic [31:0]          wdata;
        logic [3:0]           be;
    } st_entry_t;

endpackage
`default_nettype wire

// File: rtl/store_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | store_fifo: DEPTH-entry synchronous FIFO of st_entry_t that also exposes   |
// | every slot's address and liveness for hazard comparison.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module store_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  st_entry_t                  wr_entry,
    output st_entry_t                  rd_entry,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [DEPTH-1:0]           entry_valid,
    output logic [ST_ADDR_W-1:0]       entry_addr [DEPTH]
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    st_entry_t        r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    assign full   = (r_count == (PTR_W+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: liveness comes solely from the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_entry;
    end

    assign rd_entry = r_mem[r_rd_ptr];

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            logic [PTR_W-1:0] w_dist;
            assign w_dist         = PTR_W'(i) - r_rd_ptr;
            assign entry_valid[i] = ({1'b0, w_dist} < r_count);
            assign entry_addr[i]  = r_mem[i].addr;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/store_align_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | store_align_buffer: aligns M-stage stores into word writes and queues them |
// | for memory. Optional macro STORE_MISALIGN_TRAP_EN drops misaligned stores. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module store_align_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   st_validM,
    input  logic [2:0]             funct3M,
    input  logic [ADDR_W-1:0]      ALUResultM,
    input  logic [31:0]            WriteDataM,
    input  logic                   ld_validM,
    input  logic [ADDR_W-1:0]      ld_addrM,
    output logic                   st_stall,
    output logic                   ld_conflict,
    output logic                   misalign,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [3:0]             mem_be,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam logic [ADDR_W-1:0]    c_word_mask    = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ST_ADDR_W-1:0] c_st_word_mask = {{(ST_ADDR_W-2){1'b1}}, 2'b00};

    logic [1:0]           w_off;
    logic                 w_legal;
    logic [3:0]           w_be;
    logic [31:0]          w_wdata;
    logic                 w_misaligned;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_hit;
    st_entry_t            w_entry;
    st_entry_t            w_head;
    logic [DEPTH-1:0]     w_entry_valid;
    logic [ST_ADDR_W-1:0] w_entry_addr [DEPTH];
    logic [ST_ADDR_W-1:0] w_ld_ext;
    logic                 r_misalign;

    assign w_off = ALUResultM[1:0];

    always_comb begin
        w_legal = 1'b0;
        w_be    = 4'b0000;
        w_wdata = 32'h0;
        case (funct3M)
            F3_SB: begin
                w_legal = 1'b1;
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{WriteDataM[7:0]}};
            end
            F3_SH: begin
                w_legal = 1'b1;
                w_be    = 4'b0011 << {w_off[1], 1'b0};
                w_wdata = {2{WriteDataM[15:0]}};
            end
            F3_SW: begin
                w_legal = 1'b1;
                w_be    = 4'b1111;
                w_wdata = WriteDataM;
            end
            default: ;
        endcase
    end

`ifdef STORE_MISALIGN_TRAP_EN
    assign w_misaligned = ((funct3M == F3_SH) && w_off[0]) ||
                          ((funct3M == F3_SW) && (w_off != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_entry.addr  = ST_ADDR_W'(ALUResultM & c_word_mask);
    assign w_entry.wdata = w_wdata;
    assign w_entry.be    = w_be;

    // A dropped misaligned store must never hold the pipeline, even when full.
    assign st_stall = st_validM && w_legal && !w_misaligned && w_full;
    assign w_push   = st_validM && w_legal && !w_misaligned && !w_full;
    assign w_pop    = mem_valid && mem_ready;

    store_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (w_push),
        .pop         (w_pop),
        .wr_entry    (w_entry),
        .rd_entry    (w_head),
        .full        (w_full),
        .empty       (empty),
        .count       (count),
        .entry_valid (w_entry_valid),
        .entry_addr  (w_entry_addr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= st_validM && w_misaligned;
        end
    end

    assign misalign  = r_misalign;
    assign mem_valid = !empty;
    assign mem_addr  = empty ? '0    : ADDR_W'(w_head.addr);
    assign mem_wdata = empty ? 32'h0 : w_head.wdata;
    assign mem_be    = empty ? 4'h0  : w_head.be;

    assign w_ld_ext = ST_ADDR_W'(ld_addrM);

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry_valid[i] &&
                (((w_entry_addr[i] ^ w_ld_ext) & c_st_word_mask) == '0)) begin
                w_hit = 1'b1;
            end
        end
    end

    assign ld_conflict = ld_validM && w_hit;

endmodule
`default_nettype wire
